cons_inject_fifo: RTL and testbench

- Byte-wide injection FIFO plus pacing FSM for the simulated console input path.
- Upstream, the file-driven command reader pushes command-line characters.
- This block delivers them one at a time to the console receive FIFO as single-cycle write pulses with the key byte.
- Bytes are delivered only while the console side is not busy, with a programmable idle gap after each delivered byte.

---
 rtl/cons_inject_fifo.sv | 124 ++++++++++++
 tb/tb_cons_inject_fifo.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cons_inject_fifo.sv
// Byte-wide injection FIFO feeding the console receive FIFO one key at a time,
// with a fixed idle gap after each delivered byte and back-pressure from the console.
module cons_inject_fifo #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 4,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [7:0]       i_wr_data,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow,
    input  logic             i_cons_busy,
    output logic             o_we,
    output logic [7:0]       o_key
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [7:0]       key_q;
    state_t           state;
    state_t           state_nxt;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_nxt;
    logic             full;
    logic             push;
    logic             pop;

    // Fullness uses the pre-edge count, so a same-cycle pop never frees a slot.
    assign full = (count == CNT_W'(DEPTH));
    assign push = i_wr_en && !full;

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if ((count != '0) && !i_cons_busy) begin
                    pop       = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                gap_nxt   = GAP_W'(GAP_CYCLES - 1);
                state_nxt = GAP;
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt - GAP_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            state    <= IDLE;
            gap_cnt  <= '0;
            key_q    <= 8'h00;
        end else if (i_flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            state    <= IDLE;
            gap_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (i_wr_en && full) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                key_q  <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign o_we       = (state == SEND);
    assign o_key      = key_q;
    assign o_full     = full;
    assign o_count    = count;
    assign o_overflow = overflow;

endmodule

// File: tb/tb_cons_inject_fifo.sv
// Directed bench for cons_inject_fifo: vector table for the basic "ls\n" flow,
// then hand sequences for full/overflow, flush, busy during gap and reset in SEND.
module tb_cons_inject_fifo;

    logic       clk;
    logic       rst;
    logic       i_flush;
    logic       i_wr_en;
    logic [7:0] i_wr_data;
    logic       i_cons_busy;
    logic       o_full;
    logic [4:0] o_count;
    logic       o_overflow;
    logic       o_we;
    logic [7:0] o_key;
    logic       full_g1;
    logic [4:0] count_g1;
    logic       ovf_g1;
    logic       we_g1;
    logic [7:0] key_g1;

    int n_cmp = 0;
    int n_bad = 0;

    cons_inject_fifo dut (
        .clk(clk), .rst(rst), .i_flush(i_flush), .i_wr_en(i_wr_en),
        .i_wr_data(i_wr_data), .o_full(o_full), .o_count(o_count),
        .o_overflow(o_overflow), .i_cons_busy(i_cons_busy),
        .o_we(o_we), .o_key(o_key)
    );

    cons_inject_fifo #(.GAP_CYCLES(1)) dut_g1 (
        .clk(clk), .rst(rst), .i_flush(i_flush), .i_wr_en(i_wr_en),
        .i_wr_data(i_wr_data), .o_full(full_g1), .o_count(count_g1),
        .o_overflow(ovf_g1), .i_cons_busy(i_cons_busy),
        .o_we(we_g1), .o_key(key_g1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       flush;
        logic       wr_en;
        logic [7:0] wr_data;
        logic       busy;
        logic       exp_we;
        logic [7:0] exp_key;
        logic [4:0] exp_cnt;
        logic       exp_full;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(int r, int f, int w, int d, int b,
                                int we, int k, int c, int fu, int ov);
        vec_t v;
        v.rst      = r[0];
        v.flush    = f[0];
        v.wr_en    = w[0];
        v.wr_data  = d[7:0];
        v.busy     = b[0];
        v.exp_we   = we[0];
        v.exp_key  = k[7:0];
        v.exp_cnt  = c[4:0];
        v.exp_full = fu[0];
        v.exp_ovf  = ov[0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         we_seen;
        int         got;
        int         last_t;
        logic       prev_we;
        logic [7:0] keys [$];
        int         t0 [$];
        int         t1 [$];
        logic [7:0] k1 [$];
        logic [7:0] ls_str [3];

        rst = 1'b1; i_flush = 1'b0; i_wr_en = 1'b0; i_wr_data = 8'h00; i_cons_busy = 1'b0;
        ls_str[0] = 8'h6c; ls_str[1] = 8'h73; ls_str[2] = 8'h0a;

        // "ls\n" pushed back to back; pulses 6 cycles apart
        vecs[0] = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        vecs[1] = mk(0, 0, 1, 8'h6c, 0, 0, 8'h00, 1, 0, 0);
        vecs[2] = mk(0, 0, 1, 8'h73, 0, 1, 8'h6c, 1, 0, 0);
        vecs[3] = mk(0, 0, 1, 8'h0a, 0, 0, 8'h6c, 2, 0, 0);
        for (int i = 4; i <= 7; i++)   vecs[i] = mk(0, 0, 0, 0, 0, 0, 8'h6c, 2, 0, 0);
        vecs[8] = mk(0, 0, 0, 0, 0, 1, 8'h73, 1, 0, 0);
        for (int i = 9; i <= 13; i++)  vecs[i] = mk(0, 0, 0, 0, 0, 0, 8'h73, 1, 0, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 1, 8'h0a, 0, 0, 0);
        for (int i = 15; i <= 20; i++) vecs[i] = mk(0, 0, 0, 0, 0, 0, 8'h0a, 0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            rst         = vecs[i].rst;
            i_flush     = vecs[i].flush;
            i_wr_en     = vecs[i].wr_en;
            i_wr_data   = vecs[i].wr_data;
            i_cons_busy = vecs[i].busy;
            step();
            check($sformatf("vec%0d we", i),    32'(o_we),       32'(vecs[i].exp_we));
            check($sformatf("vec%0d key", i),   32'(o_key),      32'(vecs[i].exp_key));
            check($sformatf("vec%0d count", i), 32'(o_count),    32'(vecs[i].exp_cnt));
            check($sformatf("vec%0d full", i),  32'(o_full),     32'(vecs[i].exp_full));
            check($sformatf("vec%0d ovf", i),   32'(o_overflow), 32'(vecs[i].exp_ovf));
        end

        // Fill under busy, overflow with one extra push, then drain in order
        i_cons_busy = 1'b1;
        we_seen = 0;
        for (int k = 0; k < 17; k++) begin
            i_wr_en   = 1'b1;
            i_wr_data = 8'h41 + 8'(k);
            step();
            if (o_we) we_seen++;
        end
        i_wr_en = 1'b0;
        check("fill count", 32'(o_count), 32'd16);
        check("fill full", 32'(o_full), 32'd1);
        check("fill ovf", 32'(o_overflow), 32'd1);
        check("fill no we", 32'(we_seen), 32'd0);

        i_cons_busy = 1'b0;
        got = 0; last_t = 0; prev_we = 1'b0;
        for (int c = 0; c < 200 && got < 16; c++) begin
            step();
            if (o_we) begin
                check("drain back-to-back we", 32'(prev_we), 32'd0);
                if (got > 0) check("drain spacing", 32'(c - last_t), 32'd6);
                keys.push_back(o_key);
                last_t = c;
                got++;
            end
            prev_we = o_we;
        end
        check("drain pulses", 32'(got), 32'd16);
        for (int k = 0; k < keys.size(); k++)
            check($sformatf("drain key%0d", k), 32'(keys[k]), 32'(8'h41 + 8'(k)));
        we_seen = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (o_we) we_seen++;
        end
        check("no 0x51 pulse", 32'(we_seen), 32'd0);
        check("drained count", 32'(o_count), 32'd0);
        check("key holds", 32'(o_key), 32'h50);
        check("ovf sticky", 32'(o_overflow), 32'd1);

        // Flush wins over a same-cycle push
        i_cons_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i_wr_en = 1'b1; i_wr_data = 8'h60 + 8'(k);
            step();
        end
        check("pre-flush count", 32'(o_count), 32'd5);
        i_wr_data = 8'h66; i_flush = 1'b1;
        step();
        i_flush = 1'b0; i_wr_en = 1'b0;
        check("flush count", 32'(o_count), 32'd0);
        check("flush ovf", 32'(o_overflow), 32'd0);
        check("flush we", 32'(o_we), 32'd0);
        check("flush key kept", 32'(o_key), 32'h50);
        i_cons_busy = 1'b0;
        step();
        check("flush push discarded", 32'(o_we), 32'd0);
        i_wr_en = 1'b1; i_wr_data = 8'h23;
        step();
        i_wr_en = 1'b0;
        check("post-flush count", 32'(o_count), 32'd1);
        check("post-flush latency0", 32'(o_we), 32'd0);
        step();
        check("post-flush we", 32'(o_we), 32'd1);
        check("post-flush key", 32'(o_key), 32'h23);

        // Busy raised during GAP holds the second byte until IDLE sees busy low
        for (int c = 0; c < 8; c++) step();
        i_wr_en = 1'b1; i_wr_data = 8'ha1;
        step();
        i_wr_data = 8'ha2;
        step();
        i_wr_en = 1'b0;
        check("gap first we", 32'(o_we), 32'd1);
        check("gap first key", 32'(o_key), 32'ha1);
        step();
        i_cons_busy = 1'b1;
        we_seen = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (o_we) we_seen++;
        end
        check("busy holds", 32'(we_seen), 32'd0);
        check("busy count", 32'(o_count), 32'd1);
        i_cons_busy = 1'b0;
        step();
        check("release we", 32'(o_we), 32'd1);
        check("release key", 32'(o_key), 32'ha2);

        // Reset while SEND is active
        for (int c = 0; c < 8; c++) step();
        i_wr_en = 1'b1; i_wr_data = 8'hb1;
        step();
        i_wr_data = 8'hb2;
        step();
        i_wr_en = 1'b0;
        check("pre-rst we", 32'(o_we), 32'd1);
        rst = 1'b1;
        step();
        check("rst we", 32'(o_we), 32'd0);
        check("rst key", 32'(o_key), 32'h00);
        check("rst count", 32'(o_count), 32'd0);
        check("rst ovf", 32'(o_overflow), 32'd0);
        rst = 1'b0;

        // "ls\n" again on both instances; GAP_CYCLES=1 spaces pulses 3 apart
        for (int c = 0; c < 40; c++) begin
            i_wr_en = (c < 3);
            i_wr_data = (c < 3) ? ls_str[c] : 8'h00;
            step();
            if (we_g1) begin
                t1.push_back(c);
                k1.push_back(key_g1);
            end
            if (o_we) t0.push_back(c);
        end
        i_wr_en = 1'b0;
        check("g1 pulses", 32'(t1.size()), 32'd3);
        check("g4 pulses", 32'(t0.size()), 32'd3);
        if (t1.size() == 3) begin
            check("g1 latency", 32'(t1[0]), 32'd1);
            check("g1 spacing a", 32'(t1[1] - t1[0]), 32'd3);
            check("g1 spacing b", 32'(t1[2] - t1[1]), 32'd3);
            for (int k = 0; k < 3; k++)
                check($sformatf("g1 key%0d", k), 32'(k1[k]), 32'(ls_str[k]));
        end
        if (t0.size() == 3) begin
            check("g4 spacing a", 32'(t0[1] - t0[0]), 32'd6);
            check("g4 spacing b", 32'(t0[2] - t0[1]), 32'd6);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
